// File: rtl/game_flow_controller.sv
// Game sequencer: conditions the confirm button and mode switch, then steps
// MENU -> COUNTDOWN -> PLAYING -> RESULT and reports which screen owns the display.

module game_flow_debounce #(
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic raw,
  output logic level
);
  localparam int unsigned DB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;

  // cnt counts consecutive frame_ticks on which the synced level disagreed with level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (frame_tick) begin
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_FRAMES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module game_flow_controller #(
  parameter int unsigned FRAMES_PER_SEC      = 60,
  parameter int unsigned COUNTDOWN_SECS      = 3,
  parameter int unsigned DEBOUNCE_FRAMES     = 2,
  parameter int unsigned RESULT_TIMEOUT_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       sw0_mode_select,
  input  logic       p1_btn_confirm,
  input  logic       game_over,
  input  logic [1:0] game_winner,
  output logic [1:0] state_out,
  output logic       menu_active,
  output logic       mode_two_player,
  output logic [1:0] countdown_digit,
  output logic       round_start,
  output logic [1:0] winner_latched
);
  localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAYING   = 2'd2,
    RESULT    = 2'd3
  } state_t;

  state_t          state;
  logic            sw_level;
  logic            confirm_level;
  logic            confirm_prev;
  logic            confirm_press;
  logic [FC_W-1:0] frame_cnt;
  logic [2:0]      sec_cnt;
  logic            frame_last;

  game_flow_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_sw_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .raw        (sw0_mode_select),
    .level      (sw_level)
  );

  game_flow_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_confirm_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .raw        (p1_btn_confirm),
    .level      (confirm_level)
  );

  assign confirm_press = confirm_level & ~confirm_prev;
  assign frame_last    = (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));
  assign state_out     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= MENU;
      menu_active     <= 1'b1;
      mode_two_player <= 1'b0;
      countdown_digit <= '0;
      round_start     <= 1'b0;
      winner_latched  <= '0;
      frame_cnt       <= '0;
      sec_cnt         <= '0;
      confirm_prev    <= 1'b0;
    end else begin
      confirm_prev <= confirm_level;
      round_start  <= 1'b0;
      case (state)
        MENU: begin
          mode_two_player <= sw_level;
          if (confirm_press) begin
            state           <= COUNTDOWN;
            menu_active     <= 1'b0;
            countdown_digit <= 2'(COUNTDOWN_SECS);
            frame_cnt       <= '0;
          end
        end
        COUNTDOWN: begin
          if (frame_tick) begin
            if (frame_last) begin
              frame_cnt <= '0;
              if (countdown_digit == 2'd1) begin
                countdown_digit <= '0;
                state           <= PLAYING;
                round_start     <= 1'b1;
              end else begin
                countdown_digit <= countdown_digit - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        PLAYING: begin
          if (game_over) begin
            winner_latched <= game_winner;
            frame_cnt      <= '0;
            sec_cnt        <= '0;
            state          <= RESULT;
          end
        end
        RESULT: begin
          // a press pre-empts any tick in the same clk; mode is refreshed on the way out
          if (confirm_press) begin
            state           <= MENU;
            menu_active     <= 1'b1;
            mode_two_player <= sw_level;
          end else if (frame_tick) begin
            if (frame_last) begin
              frame_cnt <= '0;
              if (sec_cnt == 3'(RESULT_TIMEOUT_SECS - 1)) begin
                state           <= MENU;
                menu_active     <= 1'b1;
                mode_two_player <= sw_level;
              end else begin
                sec_cnt <= sec_cnt + 3'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= MENU;
      endcase
    end
  end
endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller with FRAMES_PER_SEC=4, DEBOUNCE=2,
// COUNTDOWN=3, RESULT_TIMEOUT=2; state changes and snapshots are checked by monitors.

module tb_game_flow_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       sw0_mode_select = 1'b0;
  logic       p1_btn_confirm = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] game_winner = 2'd0;
  logic [1:0] state_out;
  logic       menu_active;
  logic       mode_two_player;
  logic [1:0] countdown_digit;
  logic       round_start;
  logic [1:0] winner_latched;

  game_flow_controller #(
    .FRAMES_PER_SEC      (4),
    .COUNTDOWN_SECS      (3),
    .DEBOUNCE_FRAMES     (2),
    .RESULT_TIMEOUT_SECS (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .sw0_mode_select (sw0_mode_select),
    .p1_btn_confirm  (p1_btn_confirm),
    .game_over       (game_over),
    .game_winner     (game_winner),
    .state_out       (state_out),
    .menu_active     (menu_active),
    .mode_two_player (mode_two_player),
    .countdown_digit (countdown_digit),
    .round_start     (round_start),
    .winner_latched  (winner_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       menu;
    logic       mode;
    logic [1:0] digit;
    logic       rs;
    logic [1:0] win;
  } exp_t;

  exp_t  trans_q[$];
  string trans_name[$];
  exp_t  snap_q[$];
  string snap_name[$];
  event  snap_ev;
  int    checks = 0;
  int    errors = 0;
  int    rs_high = 0;

  function automatic exp_t mk(int st, int menu, int mode, int digit, int rs, int win);
    exp_t e;
    e.st = 2'(st); e.menu = 1'(menu); e.mode = 1'(mode);
    e.digit = 2'(digit); e.rs = 1'(rs); e.win = 2'(win);
    return e;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    cmp({tag, ".state"}, int'(state_out), int'(e.st));
    cmp({tag, ".menu_active"}, int'(menu_active), int'(e.menu));
    cmp({tag, ".mode"}, int'(mode_two_player), int'(e.mode));
    cmp({tag, ".digit"}, int'(countdown_digit), int'(e.digit));
    cmp({tag, ".round_start"}, int'(round_start), int'(e.rs));
    cmp({tag, ".winner"}, int'(winner_latched), int'(e.win));
  endtask

  // Transition monitor: every observed change of state_out pops one expectation.
  initial begin
    logic [1:0] prev_state;
    prev_state = 2'd0;
    forever begin
      @(negedge clk);
      if (state_out != prev_state) begin
        if (trans_q.size() == 0) begin
          cmp("unexpected_transition", int'(state_out), int'(prev_state));
        end else begin
          compare_all(trans_name.pop_front(), trans_q.pop_front());
        end
      end
      if (round_start) begin
        rs_high++;
        cmp("round_start_from_countdown", int'(prev_state), 1);
        cmp("round_start_in_playing", int'(state_out), 2);
      end
      prev_state = state_out;
    end
  end

  // Snapshot monitor: compares all outputs whenever the stimulus posts a snapshot.
  initial begin
    forever begin
      @(snap_ev);
      if (snap_q.size() == 0) cmp("snapshot_queue_empty", 0, 1);
      else compare_all(snap_name.pop_front(), snap_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  task automatic expect_trans(input string n, input exp_t e);
    trans_q.push_back(e);
    trans_name.push_back(n);
  endtask

  task automatic snap(input string n, input exp_t e);
    snap_q.push_back(e);
    snap_name.push_back(n);
    -> snap_ev;
    #1;
  endtask

  initial begin
    clks(3);
    snap("reset", mk(0, 1, 0, 0, 0, 0));
    @(negedge clk); rst = 1'b0;

    sw0_mode_select = 1'b1; clks(3); ticks(2); clks(2);
    snap("menu_sw1", mk(0, 1, 1, 0, 0, 0));
    sw0_mode_select = 1'b0; clks(3); ticks(2); clks(2);
    snap("menu_sw0", mk(0, 1, 0, 0, 0, 0));

    p1_btn_confirm = 1'b1; clks(3); ticks(1);
    p1_btn_confirm = 1'b0; clks(3); ticks(2); clks(2);
    snap("short_press", mk(0, 1, 0, 0, 0, 0));

    expect_trans("to_countdown", mk(1, 0, 0, 3, 0, 0));
    p1_btn_confirm = 1'b1; clks(3); ticks(2); clks(2);
    sw0_mode_select = 1'b1; p1_btn_confirm = 1'b0; clks(3); ticks(4); clks(2);
    snap("cd_digit2", mk(1, 0, 0, 2, 0, 0));
    p1_btn_confirm = 1'b1; clks(3); ticks(4); clks(2);
    snap("cd_digit1", mk(1, 0, 0, 1, 0, 0));
    p1_btn_confirm = 1'b0; clks(3); ticks(3); clks(2);
    snap("cd_tick11", mk(1, 0, 0, 1, 0, 0));
    expect_trans("to_playing", mk(2, 0, 0, 0, 1, 0));
    ticks(1); clks(2);
    snap("playing", mk(2, 0, 0, 0, 0, 0));

    expect_trans("to_result", mk(3, 0, 0, 0, 0, 2));
    game_winner = 2'd2; game_over = 1'b1; clks(2);
    game_over = 1'b0; game_winner = 2'd0;
    ticks(7); clks(2);
    snap("result_wait", mk(3, 0, 0, 0, 0, 2));
    expect_trans("timeout_menu", mk(0, 1, 1, 0, 0, 2));
    ticks(1); clks(2);
    snap("menu_timeout", mk(0, 1, 1, 0, 0, 2));

    expect_trans("to_countdown2", mk(1, 0, 1, 3, 0, 2));
    p1_btn_confirm = 1'b1; clks(3); ticks(2); clks(2);
    p1_btn_confirm = 1'b0; game_winner = 2'd1; game_over = 1'b1; clks(3); ticks(11); clks(2);
    snap("cd_gameover_hold", mk(1, 0, 1, 1, 0, 2));
    expect_trans("to_playing2", mk(2, 0, 1, 0, 1, 2));
    expect_trans("to_result2", mk(3, 0, 1, 0, 0, 1));
    ticks(1); clks(2);
    game_over = 1'b0; game_winner = 2'd0;

    ticks(1);
    p1_btn_confirm = 1'b1; clks(3);
    expect_trans("confirm_menu", mk(0, 1, 1, 0, 0, 1));
    ticks(2); clks(2);
    snap("menu_confirm", mk(0, 1, 1, 0, 0, 1));

    p1_btn_confirm = 1'b0; clks(3); ticks(2); clks(2);
    p1_btn_confirm = 1'b1; clks(3);
    expect_trans("to_countdown3", mk(1, 0, 1, 3, 0, 1));
    ticks(2); clks(2); ticks(4); clks(2);
    snap("cd3_digit2", mk(1, 0, 1, 2, 0, 1));

    expect_trans("async_reset", mk(0, 1, 0, 0, 0, 0));
    @(negedge clk); #2 rst = 1'b1; #1;
    snap("async_reset_now", mk(0, 1, 0, 0, 0, 0));
    clks(2); rst = 1'b0;
    clks(3); ticks(1); clks(2);
    snap("post_reset_1tick", mk(0, 1, 0, 0, 0, 0));
    expect_trans("held_btn_start", mk(1, 0, 1, 3, 0, 0));
    ticks(1); clks(2); ticks(4); clks(2);
    snap("cd4_digit2", mk(1, 0, 1, 2, 0, 0));

    clks(2);
    cmp("trans_pending", trans_q.size(), 0);
    cmp("snap_pending", snap_q.size(), 0);
    cmp("round_start_clks", rs_high, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
